// File: rtl/riscv_mem_pkg.sv
// Shared constants for the memory-port arbiter: RV32 load/store funct3 codes,
// memory access sizes, the round-robin port identifier and funct3 legality check.
package riscv_mem_pkg;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;
   localparam logic [2:0] F3_SB  = 3'd0;
   localparam logic [2:0] F3_SH  = 3'd1;
   localparam logic [2:0] F3_SW  = 3'd2;

   localparam logic [1:0] MEM_SZ_BYTE = 2'd0;
   localparam logic [1:0] MEM_SZ_HALF = 2'd1;
   localparam logic [1:0] MEM_SZ_WORD = 2'd2;

   typedef enum logic {
      PORT_IF = 1'b0,
      PORT_LS = 1'b1
   } port_e;

   function automatic logic is_legal_f3(input logic we, input logic [2:0] f3);
      if (we)
         return f3 inside {F3_SB, F3_SH, F3_SW};
      return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, response and memory-side signals for the arbiter.
// slave = the arbiter itself; master = the surrounding requesters and memory.
interface mem_port_arbiter_if #(
   parameter int AWIDTH = 32,
   parameter int DPORT  = 32
);
   logic              if_req;
   logic [AWIDTH-1:0] if_addr;
   logic              if_gnt;
   logic              if_rsp_valid;
   logic              if_rsp_ready;
   logic [DPORT-1:0]  if_rsp_data;
   logic              if_rsp_err;

   logic              ls_req;
   logic              ls_we;
   logic [2:0]        ls_funct3;
   logic [AWIDTH-1:0] ls_addr;
   logic [DPORT-1:0]  ls_wdata;
   logic              ls_gnt;
   logic              ls_rsp_valid;
   logic              ls_rsp_ready;
   logic [DPORT-1:0]  ls_rsp_data;
   logic              ls_rsp_err;

   logic              mem_wr;
   logic [1:0]        mem_byte;
   logic [AWIDTH-1:0] mem_addr;
   logic [DPORT-1:0]  mem_wdata;
   logic [DPORT-1:0]  mem_rdata;

   modport slave (
      input  if_req, if_addr, if_rsp_ready,
      output if_gnt, if_rsp_valid, if_rsp_data, if_rsp_err,
      input  ls_req, ls_we, ls_funct3, ls_addr, ls_wdata, ls_rsp_ready,
      output ls_gnt, ls_rsp_valid, ls_rsp_data, ls_rsp_err,
      output mem_wr, mem_byte, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output if_req, if_addr, if_rsp_ready,
      input  if_gnt, if_rsp_valid, if_rsp_data, if_rsp_err,
      output ls_req, ls_we, ls_funct3, ls_addr, ls_wdata, ls_rsp_ready,
      input  ls_gnt, ls_rsp_valid, ls_rsp_data, ls_rsp_err,
      input  mem_wr, mem_byte, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/load_extend.sv
// Combinational RV32 load extension of the low bytes of a raw memory word.
import riscv_mem_pkg::*;

module load_extend #(
   parameter int DPORT = 32
) (
   input  logic [2:0]       funct3,
   input  logic [DPORT-1:0] raw,
   output logic [DPORT-1:0] ext
);

   always_comb begin
      ext = '0;
      case (funct3)
         F3_LB:   ext = {{(DPORT-8){raw[7]}}, raw[7:0]};
         F3_LH:   ext = {{(DPORT-16){raw[15]}}, raw[15:0]};
         F3_LW:   ext = raw;
         F3_LBU:  ext = {{(DPORT-8){1'b0}}, raw[7:0]};
         F3_LHU:  ext = {{(DPORT-16){1'b0}}, raw[15:0]};
         default: ext = '0;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch
// and load/store, with registered per-port responses and valid/ready backpressure.
import riscv_mem_pkg::*;

module mem_port_arbiter #(
   parameter int AWIDTH = 32,
   parameter int DPORT  = 32
) (
   input  logic                clk,
   input  logic                rst,
   mem_port_arbiter_if.slave   bus
);

   logic             elig_if, elig_ls;
   logic             gnt_if, gnt_ls;
   logic             err_if, err_ls, mis_ls;
   port_e            rr_ptr, rr_next;
   logic [DPORT-1:0] ld_ext;

   load_extend #(.DPORT(DPORT)) u_load_extend (
      .funct3 (bus.ls_funct3),
      .raw    (bus.mem_rdata),
      .ext    (ld_ext)
   );

   // A port with an unaccepted response may not issue, so each has one outstanding.
   always_comb begin
      elig_if = bus.if_req & (~bus.if_rsp_valid | bus.if_rsp_ready);
      elig_ls = bus.ls_req & (~bus.ls_rsp_valid | bus.ls_rsp_ready);
      gnt_if  = 1'b0;
      gnt_ls  = 1'b0;
      rr_next = rr_ptr;
      if (!rst) begin
         if (elig_if && elig_ls) begin
            gnt_if = (rr_ptr == PORT_IF);
            gnt_ls = (rr_ptr == PORT_LS);
         end else begin
            gnt_if = elig_if;
            gnt_ls = elig_ls;
         end
      end
      if (gnt_if)
         rr_next = PORT_LS;
      else if (gnt_ls)
         rr_next = PORT_IF;
   end

   always_comb begin
      err_if = |bus.if_addr[1:0];
      mis_ls = 1'b0;
      case (bus.ls_funct3[1:0])
         MEM_SZ_HALF: mis_ls = bus.ls_addr[0];
         MEM_SZ_WORD: mis_ls = |bus.ls_addr[1:0];
         default:     mis_ls = 1'b0;
      endcase
      err_ls = mis_ls | ~is_legal_f3(bus.ls_we, bus.ls_funct3);
   end

   // Idle cycles present the load/store fields so the memory sees a stable source.
   always_comb begin
      bus.if_gnt    = gnt_if;
      bus.ls_gnt    = gnt_ls;
      bus.mem_addr  = gnt_if ? bus.if_addr : bus.ls_addr;
      bus.mem_byte  = gnt_if ? MEM_SZ_WORD : bus.ls_funct3[1:0];
      bus.mem_wdata = gnt_if ? '0 : bus.ls_wdata;
      bus.mem_wr    = gnt_ls & bus.ls_we & ~err_ls;
   end

   always_ff @(posedge clk) begin
      if (rst)
         rr_ptr <= PORT_LS;
      else
         rr_ptr <= rr_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.if_rsp_valid <= 1'b0;
         bus.if_rsp_err   <= 1'b0;
         bus.if_rsp_data  <= '0;
      end else if (gnt_if) begin
         bus.if_rsp_valid <= 1'b1;
         bus.if_rsp_err   <= err_if;
         bus.if_rsp_data  <= err_if ? '0 : bus.mem_rdata;
      end else if (bus.if_rsp_ready) begin
         bus.if_rsp_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.ls_rsp_valid <= 1'b0;
         bus.ls_rsp_err   <= 1'b0;
         bus.ls_rsp_data  <= '0;
      end else if (gnt_ls) begin
         bus.ls_rsp_valid <= 1'b1;
         bus.ls_rsp_err   <= err_ls;
         bus.ls_rsp_data  <= (err_ls | bus.ls_we) ? '0 : ld_ext;
      end else if (bus.ls_rsp_ready) begin
         bus.ls_rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small byte-array memory model.
module tb_mem_port_arbiter;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   logic [7:0] mem [0:1023];
   logic [9:0] ma;

   mem_port_arbiter_if #(.AWIDTH(32), .DPORT(32)) bus ();

   mem_port_arbiter #(.AWIDTH(32), .DPORT(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign ma = bus.mem_addr[9:0];
   assign bus.mem_rdata = {mem[ma + 10'd3], mem[ma + 10'd2], mem[ma + 10'd1], mem[ma]};

   always @(posedge clk) begin
      if (bus.mem_wr) begin
         mem[ma] = bus.mem_wdata[7:0];
         if (bus.mem_byte != 2'd0)
            mem[ma + 10'd1] = bus.mem_wdata[15:8];
         if (bus.mem_byte == 2'd2) begin
            mem[ma + 10'd2] = bus.mem_wdata[23:16];
            mem[ma + 10'd3] = bus.mem_wdata[31:24];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic ls_set(input logic req, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
      bus.ls_req    = req;
      bus.ls_we     = we;
      bus.ls_funct3 = f3;
      bus.ls_addr   = addr;
      bus.ls_wdata  = wdata;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      mem[10'h20] = 8'h44; mem[10'h21] = 8'h33; mem[10'h22] = 8'h22; mem[10'h23] = 8'h11;
      mem[10'h40] = 8'hBB; mem[10'h41] = 8'hAA; mem[10'h42] = 8'h99; mem[10'h43] = 8'h88;

      // Reset with both ports requesting, including a store
      rst = 1'b1;
      bus.if_req = 1'b1;
      bus.if_addr = 32'h20;
      bus.if_rsp_ready = 1'b1;
      bus.ls_rsp_ready = 1'b1;
      ls_set(1'b1, 1'b1, 3'd2, 32'h200, 32'hDEADBEEF);
      #1;
      chk("rst_if_gnt", {31'd0, bus.if_gnt}, 32'd0);
      chk("rst_ls_gnt", {31'd0, bus.ls_gnt}, 32'd0);
      chk("rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
      cyc();
      cyc();
      rst = 1'b0;
      bus.if_req = 1'b0;
      ls_set(1'b0, 1'b0, 3'd2, 32'h40, 32'h0);
      cyc();
      chk("post_rst_if_valid", {31'd0, bus.if_rsp_valid}, 32'd0);
      chk("post_rst_ls_valid", {31'd0, bus.ls_rsp_valid}, 32'd0);
      chk("post_rst_if_err", {31'd0, bus.if_rsp_err}, 32'd0);
      chk("post_rst_ls_err", {31'd0, bus.ls_rsp_err}, 32'd0);
      chk("post_rst_if_data", bus.if_rsp_data, 32'd0);
      chk("post_rst_ls_data", bus.ls_rsp_data, 32'd0);
      chk("rst_no_write", {mem[10'h203], mem[10'h202], mem[10'h201], mem[10'h200]}, 32'd0);

      // Contention: ls first, then alternate
      bus.if_req = 1'b1;
      bus.if_addr = 32'h20;
      ls_set(1'b1, 1'b0, 3'd2, 32'h40, 32'h0);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("cont_ls_gnt", {31'd0, bus.ls_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("cont_if_gnt", {31'd0, bus.if_gnt}, (i % 2 == 0) ? 32'd0 : 32'd1);
         cyc();
         chk("cont_ls_valid", {31'd0, bus.ls_rsp_valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("cont_if_valid", {31'd0, bus.if_rsp_valid}, (i % 2 == 0) ? 32'd0 : 32'd1);
         if (i % 2 == 0)
            chk("cont_ls_data", bus.ls_rsp_data, 32'h8899AABB);
         else
            chk("cont_if_data", bus.if_rsp_data, 32'h11223344);
      end
      bus.if_req = 1'b0;
      bus.ls_req = 1'b0;
      cyc();
      chk("cont_idle_if_valid", {31'd0, bus.if_rsp_valid}, 32'd0);

      // Stores then loads of the same word
      ls_set(1'b1, 1'b1, 3'd0, 32'h100, 32'hFFFFFF80);
      #1;
      chk("sb_mem_wr", {31'd0, bus.mem_wr}, 32'd1);
      chk("sb_mem_byte", {30'd0, bus.mem_byte}, 32'd0);
      cyc();
      chk("sb_rsp_data", bus.ls_rsp_data, 32'd0);
      ls_set(1'b1, 1'b1, 3'd1, 32'h102, 32'h00001234);
      #1;
      chk("sh_mem_byte", {30'd0, bus.mem_byte}, 32'd1);
      cyc();
      chk("sh_rsp_valid", {31'd0, bus.ls_rsp_valid}, 32'd1);
      chk("sh_rsp_err", {31'd0, bus.ls_rsp_err}, 32'd0);
      ls_set(1'b1, 1'b0, 3'd2, 32'h100, 32'h0);
      #1;
      chk("lw_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
      cyc();
      chk("lw_data", bus.ls_rsp_data, 32'h12340080);
      ls_set(1'b1, 1'b0, 3'd0, 32'h100, 32'h0);
      cyc();
      chk("lb_data", bus.ls_rsp_data, 32'hFFFFFF80);
      ls_set(1'b1, 1'b0, 3'd4, 32'h100, 32'h0);
      cyc();
      chk("lbu_data", bus.ls_rsp_data, 32'h00000080);
      ls_set(1'b1, 1'b0, 3'd5, 32'h102, 32'h0);
      cyc();
      chk("lhu_data", bus.ls_rsp_data, 32'h00001234);

      // Store followed immediately by fetch of the same word
      ls_set(1'b1, 1'b1, 3'd2, 32'h140, 32'hCAFEF00D);
      cyc();
      bus.ls_req = 1'b0;
      bus.if_req = 1'b1;
      bus.if_addr = 32'h140;
      #1;
      chk("sf_if_gnt", {31'd0, bus.if_gnt}, 32'd1);
      cyc();
      chk("sf_if_data", bus.if_rsp_data, 32'hCAFEF00D);

      // Misaligned accesses
      bus.if_req = 1'b0;
      ls_set(1'b1, 1'b0, 3'd1, 32'h101, 32'h0);
      #1;
      chk("mis_lh_gnt", {31'd0, bus.ls_gnt}, 32'd1);
      chk("mis_lh_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
      cyc();
      chk("mis_lh_err", {31'd0, bus.ls_rsp_err}, 32'd1);
      chk("mis_lh_data", bus.ls_rsp_data, 32'd0);
      ls_set(1'b1, 1'b1, 3'd2, 32'h102, 32'hFFFFFFFF);
      #1;
      chk("mis_sw_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
      cyc();
      chk("mis_sw_err", {31'd0, bus.ls_rsp_err}, 32'd1);
      ls_set(1'b1, 1'b0, 3'd2, 32'h100, 32'h0);
      cyc();
      chk("mis_sw_unchanged", bus.ls_rsp_data, 32'h12340080);
      chk("mis_lw_err", {31'd0, bus.ls_rsp_err}, 32'd0);
      bus.ls_req = 1'b0;
      bus.if_req = 1'b1;
      bus.if_addr = 32'h6;
      cyc();
      chk("mis_if_err", {31'd0, bus.if_rsp_err}, 32'd1);
      chk("mis_if_data", bus.if_rsp_data, 32'd0);

      // Backpressure on the fetch response
      bus.if_req = 1'b0;
      cyc();
      bus.if_req = 1'b1;
      bus.if_addr = 32'h20;
      bus.if_rsp_ready = 1'b0;
      #1;
      chk("bp_first_gnt", {31'd0, bus.if_gnt}, 32'd1);
      cyc();
      chk("bp_if_data", bus.if_rsp_data, 32'h11223344);
      ls_set(1'b1, 1'b0, 3'd2, 32'h40, 32'h0);
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("bp_if_gnt_held", {31'd0, bus.if_gnt}, 32'd0);
         chk("bp_ls_gnt", {31'd0, bus.ls_gnt}, 32'd1);
         cyc();
         chk("bp_if_valid_held", {31'd0, bus.if_rsp_valid}, 32'd1);
         chk("bp_ls_data", bus.ls_rsp_data, 32'h8899AABB);
      end
      bus.if_rsp_ready = 1'b1;
      #1;
      chk("bp_release_if_gnt", {31'd0, bus.if_gnt}, 32'd1);
      chk("bp_release_ls_gnt", {31'd0, bus.ls_gnt}, 32'd0);
      cyc();
      chk("bp_b2b_if_valid", {31'd0, bus.if_rsp_valid}, 32'd1);
      chk("bp_ls_valid_clear", {31'd0, bus.ls_rsp_valid}, 32'd0);

      // Illegal funct3 under contention; round robin keeps alternating
      ls_set(1'b1, 1'b0, 3'd3, 32'h100, 32'h0);
      #1;
      chk("ill_ld_ls_gnt", {31'd0, bus.ls_gnt}, 32'd1);
      chk("ill_ld_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
      cyc();
      chk("ill_ld_err", {31'd0, bus.ls_rsp_err}, 32'd1);
      chk("ill_ld_data", bus.ls_rsp_data, 32'd0);
      ls_set(1'b1, 1'b1, 3'd4, 32'h100, 32'h55555555);
      #1;
      chk("ill_rr_if_gnt", {31'd0, bus.if_gnt}, 32'd1);
      cyc();
      chk("ill_rr_if_data", bus.if_rsp_data, 32'h11223344);
      chk("ill_st_ls_gnt", {31'd0, bus.ls_gnt}, 32'd1);
      chk("ill_st_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
      cyc();
      chk("ill_st_err", {31'd0, bus.ls_rsp_err}, 32'd1);
      bus.if_req = 1'b0;
      ls_set(1'b1, 1'b0, 3'd2, 32'h100, 32'h0);
      cyc();
      chk("ill_st_unchanged", bus.ls_rsp_data, 32'h12340080);
      bus.ls_req = 1'b0;
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
